fb_promote_stream: RTL and testbench



---
 rtl/fb_promote_stream_if.sv | 33 +++
 rtl/fb_promote_stream.sv | 182 ++++++++++++++++++
 tb/tb_fb_promote_stream.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_promote_stream_if.sv
// Stream bundle for the framebuffer promoter: input beat handshake, output
// beat handshake with promoted channels, and the sticky format-error flag.
interface fb_promote_stream_if #(
  parameter int unsigned NUM_PIX = 2,
  parameter int unsigned OUT_W   = 16,
  parameter int unsigned TAG_W   = 8
);
  logic                       in_valid;
  logic                       in_ready;
  logic [16*NUM_PIX-1:0]      in_data;
  logic [1:0]                 in_fmt;
  logic [TAG_W-1:0]           in_tag;
  logic                       out_valid;
  logic                       out_ready;
  logic [NUM_PIX*OUT_W-1:0]   out_r;
  logic [NUM_PIX*OUT_W-1:0]   out_g;
  logic [NUM_PIX*OUT_W-1:0]   out_b;
  logic [NUM_PIX*OUT_W-1:0]   out_a;
  logic [TAG_W-1:0]           out_tag;
  logic                       fmt_err;

  // Producer of input beats and consumer of output beats.
  modport master (
    output in_valid, in_data, in_fmt, in_tag, out_ready,
    input  in_ready, out_valid, out_r, out_g, out_b, out_a, out_tag, fmt_err
  );

  // The promoter itself.
  modport slave (
    input  in_valid, in_data, in_fmt, in_tag, out_ready,
    output in_ready, out_valid, out_r, out_g, out_b, out_a, out_tag, fmt_err
  );
endinterface

// File: rtl/fb_promote_stream.sv
// Two-stage back-pressured framebuffer readback promoter. Expands RGB565,
// ARGB1555 and ARGB4444 pixels to unsigned fixed point where 0 maps to 0.0
// and full scale maps to exactly 1.0, carrying a sideband tag alongside.
module fb_promote_stream #(
  parameter int unsigned NUM_PIX   = 2,
  parameter int unsigned FRAC_BITS = 12,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned TAG_W     = 8
) (
  input logic                clk,
  input logic                rst,
  fb_promote_stream_if.slave bus
);

  localparam int unsigned DataW = 16 * NUM_PIX;
  localparam int unsigned ChW   = NUM_PIX * OUT_W;

  // Exact 1.0 in the output fixed-point format.
  localparam logic [OUT_W-1:0] One = {{(OUT_W-1){1'b0}}, 1'b1} << FRAC_BITS;

  typedef enum logic [1:0] {
    FmtRgb565   = 2'b00,
    FmtArgb1555 = 2'b01,
    FmtArgb4444 = 2'b10,
    FmtRsvd     = 2'b11
  } fmt_e;

  // Replicate the n-bit code MSB-first into FRAC_BITS, then add the MSB back
  // in so all-ones lands on exactly 1.0 while zero stays zero.
  function automatic logic [OUT_W-1:0] promote(input logic [5:0] c, input int unsigned n);
    logic [FRAC_BITS-1:0] e;
    logic [FRAC_BITS:0]   q;
    logic [2:0]           idx;
    e = '0;
    for (int unsigned j = 0; j < FRAC_BITS; j++) begin
      idx = 3'(n - 1 - (j % n));
      e   = {e[FRAC_BITS-2:0], c[idx]};
    end
    q = {1'b0, e} + {{FRAC_BITS{1'b0}}, e[FRAC_BITS-1]};
    return OUT_W'(q);
  endfunction

  // Stage 1: raw beat.
  logic             s1_v_q, s1_v_d;
  logic [DataW-1:0] s1_data_q, s1_data_d;
  fmt_e             s1_fmt_q, s1_fmt_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  // Stage 2: promoted beat, drives the outputs directly.
  logic             s2_v_q, s2_v_d;
  logic [ChW-1:0]   r_q, r_d;
  logic [ChW-1:0]   g_q, g_d;
  logic [ChW-1:0]   b_q, b_d;
  logic [ChW-1:0]   a_q, a_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             fmt_err_q, fmt_err_d;

  logic             in_ready;
  logic             in_fire;
  logic             out_fire;
  logic             s2_load;
  logic [ChW-1:0]   prom_r, prom_g, prom_b, prom_a;

  // S1 can take a beat whenever it is empty or is about to move into S2.
  assign in_ready = !s1_v_q || !s2_v_q || bus.out_ready;
  assign in_fire  = bus.in_valid && in_ready;
  assign out_fire = s2_v_q && bus.out_ready;
  assign s2_load  = s1_v_q && (!s2_v_q || bus.out_ready);

  // Channel promotion of the beat held in S1.
  always_comb begin : promote_chans
    logic [15:0] pix;
    prom_r = '0;
    prom_g = '0;
    prom_b = '0;
    prom_a = '0;
    pix    = '0;
    for (int unsigned p = 0; p < NUM_PIX; p++) begin
      pix = s1_data_q[16*p +: 16];
      unique case (s1_fmt_q)
        FmtRgb565: begin
          prom_r[p*OUT_W +: OUT_W] = promote({1'b0, pix[15:11]}, 5);
          prom_g[p*OUT_W +: OUT_W] = promote(pix[10:5], 6);
          prom_b[p*OUT_W +: OUT_W] = promote({1'b0, pix[4:0]}, 5);
          prom_a[p*OUT_W +: OUT_W] = One;
        end
        FmtArgb1555: begin
          prom_r[p*OUT_W +: OUT_W] = promote({1'b0, pix[14:10]}, 5);
          prom_g[p*OUT_W +: OUT_W] = promote({1'b0, pix[9:5]}, 5);
          prom_b[p*OUT_W +: OUT_W] = promote({1'b0, pix[4:0]}, 5);
          prom_a[p*OUT_W +: OUT_W] = promote({5'b0, pix[15]}, 1);
        end
        FmtArgb4444: begin
          prom_r[p*OUT_W +: OUT_W] = promote({2'b0, pix[11:8]}, 4);
          prom_g[p*OUT_W +: OUT_W] = promote({2'b0, pix[7:4]}, 4);
          prom_b[p*OUT_W +: OUT_W] = promote({2'b0, pix[3:0]}, 4);
          prom_a[p*OUT_W +: OUT_W] = promote({2'b0, pix[15:12]}, 4);
        end
        FmtRsvd: begin
          // Reserved format forwards an all-zero beat.
        end
      endcase
    end
  end

  // Next-state for both pipeline stages and the sticky error flag.
  always_comb begin : next_state
    s1_v_d    = s1_v_q;
    s1_data_d = s1_data_q;
    s1_fmt_d  = s1_fmt_q;
    s1_tag_d  = s1_tag_q;
    s2_v_d    = s2_v_q;
    r_d       = r_q;
    g_d       = g_q;
    b_d       = b_q;
    a_d       = a_q;
    tag_d     = tag_q;
    fmt_err_d = fmt_err_q;

    if (s2_load) begin
      s2_v_d = 1'b1;
      r_d    = prom_r;
      g_d    = prom_g;
      b_d    = prom_b;
      a_d    = prom_a;
      tag_d  = s1_tag_q;
    end else if (out_fire) begin
      s2_v_d = 1'b0;
    end

    if (in_fire) begin
      s1_v_d    = 1'b1;
      s1_data_d = bus.in_data;
      s1_fmt_d  = fmt_e'(bus.in_fmt);
      s1_tag_d  = bus.in_tag;
      if (fmt_e'(bus.in_fmt) == FmtRsvd) begin
        fmt_err_d = 1'b1;
      end
    end else if (s2_load) begin
      s1_v_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_data_q <= '0;
      s1_fmt_q  <= FmtRgb565;
      s1_tag_q  <= '0;
      s2_v_q    <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      a_q       <= '0;
      tag_q     <= '0;
      fmt_err_q <= 1'b0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_data_q <= s1_data_d;
      s1_fmt_q  <= s1_fmt_d;
      s1_tag_q  <= s1_tag_d;
      s2_v_q    <= s2_v_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      a_q       <= a_d;
      tag_q     <= tag_d;
      fmt_err_q <= fmt_err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_v_q;
  assign bus.out_r     = r_q;
  assign bus.out_g     = g_q;
  assign bus.out_b     = b_q;
  assign bus.out_a     = a_q;
  assign bus.out_tag   = tag_q;
  assign bus.fmt_err   = fmt_err_q;

endmodule

// File: tb/tb_fb_promote_stream.sv
// Bench for fb_promote_stream: default build (2 pixels, 12 fraction bits) and
// a narrow build (1 pixel, 8 fraction bits, 9-bit channels) on one clock.
module tb_fb_promote_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  fb_promote_stream_if #(.NUM_PIX(2), .OUT_W(16), .TAG_W(8)) bus ();
  fb_promote_stream #(.NUM_PIX(2), .FRAC_BITS(12), .OUT_W(16), .TAG_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  fb_promote_stream_if #(.NUM_PIX(1), .OUT_W(9), .TAG_W(8)) sbus ();
  fb_promote_stream #(.NUM_PIX(1), .FRAC_BITS(8), .OUT_W(9), .TAG_W(8)) sdut (
    .clk(clk), .rst(rst), .bus(sbus)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  f;
    logic [7:0]  t;
  } beat_t;

  // Reference: truncating an endlessly repeated n-bit code equals
  // floor(c * 2^fb / (2^n - 1)), except all-ones which truncates to 2^fb - 1.
  function automatic int unsigned pr(input int unsigned c, input int unsigned n,
                                     input int unsigned fb);
    longint unsigned full, e;
    full = (64'd1 << n) - 64'd1;
    if (64'(c) == full) e = (64'd1 << fb) - 64'd1;
    else e = (64'(c) << fb) / full;
    if (e >= (64'd1 << (fb - 1))) e = e + 64'd1;
    return 32'(e);
  endfunction

  // ch: 0=r 1=g 2=b 3=a
  function automatic int unsigned exp_chan(input logic [15:0] w, input logic [1:0] f,
                                           input int ch, input int unsigned fb);
    int unsigned v [4];
    v = '{0, 0, 0, 0};
    case (f)
      2'b00: v = '{pr(32'(w[15:11]), 5, fb), pr(32'(w[10:5]), 6, fb),
                   pr(32'(w[4:0]), 5, fb), 32'd1 << fb};
      2'b01: v = '{pr(32'(w[14:10]), 5, fb), pr(32'(w[9:5]), 5, fb),
                   pr(32'(w[4:0]), 5, fb), pr(32'(w[15]), 1, fb)};
      2'b10: v = '{pr(32'(w[11:8]), 4, fb), pr(32'(w[7:4]), 4, fb),
                   pr(32'(w[3:0]), 4, fb), pr(32'(w[15:12]), 4, fb)};
      default: v = '{0, 0, 0, 0};
    endcase
    return v[ch];
  endfunction

  // Stimulus only: present one beat to an empty pipeline with out_ready high,
  // then count edges until out_valid (bounded).
  task automatic send_beat(input logic [31:0] data, input logic [1:0] fmt,
                           input logic [7:0] tag, output int lat);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = data; bus.in_fmt = fmt; bus.in_tag = tag;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++;
      $display("FAIL reset_out_valid got=%0h exp=0", bus.out_valid); end
    checks++; if (bus.fmt_err !== 1'b0) begin failures++;
      $display("FAIL reset_fmt_err got=%0h exp=0", bus.fmt_err); end
    checks++; if ({bus.out_r, bus.out_g, bus.out_b, bus.out_a} !== 128'd0) begin failures++;
      $display("FAIL reset_channels got=%h exp=0", {bus.out_r, bus.out_g, bus.out_b, bus.out_a});
    end
    checks++; if (bus.out_tag !== 8'h00) begin failures++;
      $display("FAIL reset_out_tag got=%h exp=00", bus.out_tag); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++;
      $display("FAIL reset_in_ready got=%0h exp=1", bus.in_ready); end
    checks++; if (sbus.in_ready !== 1'b1 || sbus.out_valid !== 1'b0) begin failures++;
      $display("FAIL reset_small got=%0h%0h exp=10", sbus.in_ready, sbus.out_valid); end
  endtask

  task automatic test_rgb565();
    int lat;
    send_beat({16'h0000, 16'hFFFF}, 2'b00, 8'h01, lat);
    checks++; if (lat !== 2) begin failures++;
      $display("FAIL rgb565_latency got=%0d exp=2", lat); end
    checks++; if (bus.out_r !== {16'h0000, 16'h1000} || bus.out_g !== {16'h0000, 16'h1000} ||
                  bus.out_b !== {16'h0000, 16'h1000}) begin failures++;
      $display("FAIL rgb565_white_black got=%h/%h/%h exp=00001000",
               bus.out_r, bus.out_g, bus.out_b); end
    checks++; if (bus.out_a !== {16'h1000, 16'h1000} || bus.out_tag !== 8'h01) begin failures++;
      $display("FAIL rgb565_alpha_tag got=%h/%h exp=10001000/01", bus.out_a, bus.out_tag); end
    send_beat({16'h0000, 16'h8410}, 2'b00, 8'h02, lat);
    checks++; if (lat !== 2) begin failures++;
      $display("FAIL rgb565_latency2 got=%0d exp=2", lat); end
    checks++; if (bus.out_r !== {16'h0000, 16'h0843}) begin failures++;
      $display("FAIL rgb565_mid_r got=%h exp=00000843", bus.out_r); end
    checks++; if (bus.out_g !== {16'h0000, 16'h0821}) begin failures++;
      $display("FAIL rgb565_mid_g got=%h exp=00000821", bus.out_g); end
    checks++; if (bus.out_b !== {16'h0000, 16'h0843}) begin failures++;
      $display("FAIL rgb565_mid_b got=%h exp=00000843", bus.out_b); end
    checks++; if (bus.out_a !== {16'h1000, 16'h1000}) begin failures++;
      $display("FAIL rgb565_mid_a got=%h exp=10001000", bus.out_a); end
  endtask

  task automatic test_argb1555();
    int lat;
    // pixel 0 = 0x8000, pixel 1 = 0x7FFF
    send_beat({16'h7FFF, 16'h8000}, 2'b01, 8'h03, lat);
    checks++; if (bus.out_a !== {16'h0000, 16'h1000}) begin failures++;
      $display("FAIL argb1555_a got=%h exp=00001000", bus.out_a); end
    checks++; if (bus.out_r !== {16'h1000, 16'h0000} || bus.out_g !== {16'h1000, 16'h0000} ||
                  bus.out_b !== {16'h1000, 16'h0000}) begin failures++;
      $display("FAIL argb1555_rgb got=%h/%h/%h exp=10000000",
               bus.out_r, bus.out_g, bus.out_b); end
  endtask

  task automatic test_argb4444();
    int lat;
    // pixel 0 = 0x0F0F, pixel 1 = 0xF0F0
    send_beat({16'hF0F0, 16'h0F0F}, 2'b10, 8'h04, lat);
    checks++; if (bus.out_r !== {16'h0000, 16'h1000}) begin failures++;
      $display("FAIL argb4444_r got=%h exp=00001000", bus.out_r); end
    checks++; if (bus.out_g !== {16'h1000, 16'h0000}) begin failures++;
      $display("FAIL argb4444_g got=%h exp=10000000", bus.out_g); end
    checks++; if (bus.out_b !== {16'h0000, 16'h1000}) begin failures++;
      $display("FAIL argb4444_b got=%h exp=00001000", bus.out_b); end
    checks++; if (bus.out_a !== {16'h1000, 16'h0000}) begin failures++;
      $display("FAIL argb4444_a got=%h exp=10000000", bus.out_a); end
  endtask

  task automatic test_reserved();
    int lat;
    checks++; if (bus.fmt_err !== 1'b0) begin failures++;
      $display("FAIL reserved_err_before got=%0h exp=0", bus.fmt_err); end
    send_beat({16'h1234, 16'h1234}, 2'b11, 8'h5A, lat);
    checks++; if (lat !== 2 || bus.out_tag !== 8'h5A) begin failures++;
      $display("FAIL reserved_tag got=%0d/%h exp=2/5a", lat, bus.out_tag); end
    checks++; if ({bus.out_r, bus.out_g, bus.out_b, bus.out_a} !== 128'd0) begin failures++;
      $display("FAIL reserved_zero got=%h exp=0", {bus.out_r, bus.out_g, bus.out_b, bus.out_a});
    end
    checks++; if (bus.fmt_err !== 1'b1) begin failures++;
      $display("FAIL reserved_err got=%0h exp=1", bus.fmt_err); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.fmt_err !== 1'b1) begin failures++;
      $display("FAIL reserved_err_sticky got=%0h exp=1", bus.fmt_err); end
  endtask

  task automatic test_random();
    beat_t        q[$];
    beat_t        b;
    int           sent = 0;
    int           got = 0;
    int           cyc = 0;
    logic         stalled = 1'b0;
    logic         need_new = 1'b1;
    logic [135:0] saved = '0;
    logic [127:0] exp_ch;
    logic [127:0] act_ch;
    bus.in_valid = 1'b0;
    while (got < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        checks++;
        if ({bus.out_r, bus.out_g, bus.out_b, bus.out_a, bus.out_tag} !== saved) begin
          failures++;
          $display("FAIL random_stall_hold got=%h exp=%h",
                   {bus.out_r, bus.out_g, bus.out_b, bus.out_a, bus.out_tag}, saved);
        end
      end
      if (need_new) begin
        if (sent < 1000) begin
          bus.in_valid = 1'b1;
          bus.in_data  = $urandom;
          bus.in_fmt   = 2'($urandom_range(0, 3));
          bus.in_tag   = sent[7:0];
        end else begin
          bus.in_valid = 1'b0;
        end
        need_new = 1'b0;
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL random_extra_beat got_tag=%h exp=none", bus.out_tag);
        end else begin
          b = q.pop_front();
          for (int p = 0; p < 2; p++) begin
            exp_ch[96 + p*16 +: 16] = 16'(exp_chan(b.d[p*16 +: 16], b.f, 0, 12));
            exp_ch[64 + p*16 +: 16] = 16'(exp_chan(b.d[p*16 +: 16], b.f, 1, 12));
            exp_ch[32 + p*16 +: 16] = 16'(exp_chan(b.d[p*16 +: 16], b.f, 2, 12));
            exp_ch[p*16 +: 16]      = 16'(exp_chan(b.d[p*16 +: 16], b.f, 3, 12));
          end
          act_ch = {bus.out_r, bus.out_g, bus.out_b, bus.out_a};
          if (bus.out_tag !== b.t || act_ch !== exp_ch) begin
            failures++;
            $display("FAIL random_beat got=%h/%h exp=%h/%h", bus.out_tag, act_ch, b.t, exp_ch);
          end
        end
        got++;
      end
      stalled = bus.out_valid && !bus.out_ready;
      saved   = {bus.out_r, bus.out_g, bus.out_b, bus.out_a, bus.out_tag};
      if (bus.in_valid && bus.in_ready) begin
        q.push_back('{d: bus.in_data, f: bus.in_fmt, t: bus.in_tag});
        sent++;
        need_new = 1'b1;
      end
    end
    checks++; if (got != 1000 || q.size() != 0) begin failures++;
      $display("FAIL random_complete got=%0d left=%0d exp=1000/0", got, q.size()); end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_stall();
    int acc = 0;
    bus.in_data = {16'h1234, 16'h5678};
    bus.in_fmt  = 2'b00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.out_ready = 1'b0; bus.in_valid = 1'b1;
      bus.in_tag = 8'hA0 + acc[7:0];
      #1;
      if (bus.in_ready) acc++;
    end
    checks++; if (acc != 2) begin failures++;
      $display("FAIL stall_accepted got=%0d exp=2", acc); end
    @(negedge clk);
    bus.in_tag = 8'hA0 + acc[7:0];
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++;
      $display("FAIL stall_in_ready_low got=%0h exp=0", bus.in_ready); end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++;
      $display("FAIL stall_in_ready_release got=%0h exp=1", bus.in_ready); end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      bus.in_tag = 8'hA0 + acc[7:0];
      bus.out_ready = 1'b1;
      #1;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 8'hA0 + 8'(k)) begin failures++;
        $display("FAIL stall_drain_%0d got=%0h/%h exp=1/%h", k, bus.out_valid, bus.out_tag,
                 8'hA0 + 8'(k)); end
      if (bus.in_ready) acc++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_tag = 8'hC0 + 8'(i);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin failures++;
      $display("FAIL midrst_inflight got=%0h%0h exp=10", bus.out_valid, bus.in_ready); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.fmt_err !== 1'b0 || bus.out_tag !== 8'h00)
    begin failures++;
      $display("FAIL midrst_cleared got=%0h/%0h/%h exp=0/0/00", bus.out_valid, bus.fmt_err,
               bus.out_tag); end
    @(negedge clk);
    rst = 1'b0; bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    checks++; if (seen != 0) begin failures++;
      $display("FAIL midrst_stale got=%0d exp=0", seen); end
  endtask

  task automatic test_small();
    @(negedge clk);
    sbus.in_valid = 1'b1; sbus.in_data = 16'hFFFF; sbus.in_fmt = 2'b00; sbus.in_tag = 8'h33;
    sbus.out_ready = 1'b1;
    @(posedge clk); #1;
    sbus.in_valid = 1'b0;
    checks++; if (sbus.out_valid !== 1'b0) begin failures++;
      $display("FAIL small_early got=%0h exp=0", sbus.out_valid); end
    @(posedge clk); #1;
    checks++; if (sbus.out_valid !== 1'b1 || sbus.out_tag !== 8'h33) begin failures++;
      $display("FAIL small_valid got=%0h/%h exp=1/33", sbus.out_valid, sbus.out_tag); end
    checks++; if ({sbus.out_r, sbus.out_g, sbus.out_b, sbus.out_a} !== {4{9'h100}}) begin
      failures++;
      $display("FAIL small_white got=%h exp=%h", {sbus.out_r, sbus.out_g, sbus.out_b,
               sbus.out_a}, {4{9'h100}}); end
    @(negedge clk);
    sbus.in_valid = 1'b1; sbus.in_data = 16'h8421; sbus.in_fmt = 2'b10; sbus.in_tag = 8'h34;
    @(posedge clk); #1;
    sbus.in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if ({sbus.out_r, sbus.out_g, sbus.out_b, sbus.out_a} !==
                  {9'h044, 9'h022, 9'h011, 9'h089} || sbus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL small_4444 got=%h exp=%h", {sbus.out_r, sbus.out_g, sbus.out_b,
               sbus.out_a}, {9'h044, 9'h022, 9'h011, 9'h089}); end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_fmt = 2'b00; bus.in_tag = '0;
    bus.out_ready = 1'b1;
    sbus.in_valid = 1'b0; sbus.in_data = '0; sbus.in_fmt = 2'b00; sbus.in_tag = '0;
    sbus.out_ready = 1'b1;
    test_reset();
    test_rgb565();
    test_argb1555();
    test_argb4444();
    test_reserved();
    test_random();
    test_stall();
    test_reset_mid();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
